// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface lsu_bus_if #(
  parameter int ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-3:0] addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: req/gnt/rvalid handshake, pipeline stall,
// misaligned/illegal/timeout reporting.
//
// state  | meaning
// IDLE   | waiting for an access; accepts and stalls in the same cycle
// REQ    | bus_req high, request fields held until gnt
// WAIT   | load granted, waiting for rvalid
// DONE   | one-cycle retire pulse with result and flags
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_read_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       write_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              misaligned_o,
  output logic              illegal_o,
  output logic              bus_err_o,
  lsu_bus_if.master         bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_load_q, is_load_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;
  logic              err_q, err_d;
  logic [31:0]       ldata_q, ldata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        accept;
  logic        in_ill;
  logic        in_mis;
  logic        timeout_hit;
  logic [3:0]  strb_al;
  logic [31:0] wdata_al;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (bus.rdata),
    .wstrb_o     (strb_al),
    .wdata_o     (wdata_al),
    .load_data_o (ld_ext)
  );

  assign accept      = mem_valid_i & (mem_read_i | mem_wr_i);
  assign in_ill      = (mem_read_i & mem_wr_i) | ~f3_legal(mem_read_i, funct3_i);
  assign in_mis      = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                       ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      err_q     <= 1'b0;
      ldata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
      err_q     <= err_d;
      ldata_q   <= ldata_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    is_load_d = is_load_q;
    mis_d     = mis_q;
    ill_d     = ill_q;
    err_d     = err_q;
    ldata_d   = ldata_q;
    cnt_d     = cnt_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          addr_d    = addr_i;
          funct3_d  = funct3_i;
          wdata_d   = write_data_i;
          is_load_d = mem_read_i;
          ill_d     = in_ill;
          mis_d     = ~in_ill & in_mis;
          err_d     = 1'b0;
          ldata_d   = '0;
          cnt_d     = '0;
          state_d   = (in_ill | in_mis) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (bus.gnt) state_d = is_load_q ? S_WAIT : S_DONE;
        // A load granted on the last allowed cycle still cannot complete in time.
        if (timeout_hit && !(bus.gnt && !is_load_q)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ldata_d = '0;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (bus.rvalid) begin
          ldata_d = ld_ext;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ldata_d = '0;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req      = (state_q == S_REQ);
  assign bus.we       = (state_q == S_REQ) & ~is_load_q;
  assign bus.addr     = addr_q[ADDR_W-1:2];
  assign bus.wstrb    = bus.we ? strb_al : 4'b0000;
  assign bus.wdata    = wdata_al;

  assign load_data_o  = ldata_q;
  assign misaligned_o = done_o & mis_q;
  assign illegal_o    = done_o & ill_q;
  assign bus_err_o    = done_o & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed corner cases plus random traffic
// against a memory responder with programmable grant/rvalid delays.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              mem_valid, mem_read, mem_wr;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       write_data;
  logic              stall, done, misaligned, illegal, bus_err;
  logic [31:0]       load_data;

  lsu_bus_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid_i  (mem_valid),
    .mem_read_i   (mem_read),
    .mem_wr_i     (mem_wr),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .write_data_i (write_data),
    .stall_o      (stall),
    .done_o       (done),
    .load_data_o  (load_data),
    .misaligned_o (misaligned),
    .illegal_o    (illegal),
    .bus_err_o    (bus_err),
    .bus          (bus)
  );

  typedef struct {
    bit          chk_ld;
    logic [31:0] ld;
    logic        mis, ill, err;
    int          done_cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy = 0;

  bit                bus_exp_v = 0;
  logic              bus_exp_we;
  logic [ADDR_W-3:0] bus_exp_addr;
  logic [3:0]        bus_exp_strb;
  logic [31:0]       bus_exp_wdata;

  int          gnt_wait = 0, rv_wait = 1, req_cnt = 0, rv_cnt = 0;
  bit          never_gnt = 0, rv_pend = 0;
  logic [31:0] mem_word = '0;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: grants after gnt_wait request cycles, returns data rv_wait cycles later.
  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = $urandom;
      if (rv_pend) begin
        if (rv_cnt <= 0) begin
          bus.rvalid = 1'b1; bus.rdata = mem_word; rv_pend = 0;
        end else rv_cnt--;
      end
      if (bus.req && !rst) begin
        if (!never_gnt && req_cnt == gnt_wait) begin
          bus.gnt = 1'b1; req_cnt = 0;
          if (!bus.we) begin rv_pend = 1; rv_cnt = rv_wait - 1; end
        end else req_cnt++;
      end else req_cnt = 0;
    end
  end

  // Monitor: bus fields while requesting, stall consistency, retire results.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) check("stall_busy", 32'(stall), 32'(!done));
      else begin
        check("stall_idle", 32'(stall), 32'd0);
        check("req_idle", 32'(bus.req), 32'd0);
      end
      if (bus.req) begin
        if (!bus_exp_v) begin
          errors++;
          $display("FAIL unexpected_req: got req=1 expected req=0 (cycle %0d)", cyc);
        end else begin
          check("bus_we", 32'(bus.we), 32'(bus_exp_we));
          check("bus_addr", 32'(bus.addr), 32'(bus_exp_addr));
          check("bus_wstrb", 32'(bus.wstrb), 32'(bus_exp_strb));
          if (bus_exp_we) check("bus_wdata", bus.wdata, bus_exp_wdata);
          if (bus.gnt) bus_exp_v = 0;
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("misaligned", 32'(misaligned), 32'(e.mis));
          check("illegal", 32'(illegal), 32'(e.ill));
          check("bus_err", 32'(bus_err), 32'(e.err));
          if (e.chk_ld) check("load_data", load_data, e.ld);
        end
        busy = 0;
        bus_exp_v = 0;
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    longint v;
    int n;
    n = 1 << f3[1:0];
    if (n == 4) return w;
    v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (f3 < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 4 * TIMEOUT + 20 && busy; k++) @(negedge clk);
    if (busy) begin
      errors++;
      $display("FAIL retire_timeout: got no done expected done (cycle %0d)", cyc);
      busy = 0; sbq.delete();
    end
    for (int k = 0; k < 4 * TIMEOUT + 20 && rv_pend; k++) @(negedge clk);
    rv_pend = 0;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                       input logic [31:0] wd, input logic [31:0] rw, input int gw, input int rvw,
                       input bit ng);
    exp_t e;
    bit ill, mis, granted, ok;
    int n, off;
    @(posedge clk); #1;
    gnt_wait = gw; rv_wait = rvw; never_gnt = ng; mem_word = rw;
    mem_valid = 1'b1; mem_read = rd; mem_wr = wr; funct3 = f3; addr = a; write_data = wd;
    if (rd || wr) begin
      n   = 1 << f3[1:0];
      off = int'(a) % 4;
      if (rd && wr) ill = 1;
      else if (rd) ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      else ill = !(f3 inside {3'd0, 3'd1, 3'd2});
      mis = !ill && (int'(a) % n != 0);
      e.ill = ill; e.mis = mis; e.err = 0; e.chk_ld = 0; e.ld = '0;
      if (ill || mis) e.done_cyc = cyc + 1;
      else begin
        granted = !ng && (gw + 1 <= TIMEOUT);
        ok = rd ? (granted && gw + 1 + rvw <= TIMEOUT) : granted;
        e.err = !ok;
        e.done_cyc = cyc + (!ok ? TIMEOUT + 1 : (rd ? gw + rvw + 2 : gw + 2));
        if (rd) begin
          e.chk_ld = 1;
          e.ld = ok ? model_load(f3, off, rw) : 32'd0;
        end
        bus_exp_we   = wr;
        bus_exp_addr = a[ADDR_W-1:2];
        bus_exp_strb = wr ? 4'(((1 << n) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) bus_exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        bus_exp_v = 1;
      end
      sbq.push_back(e);
      busy = 1;
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; funct3 = 3'($urandom); addr = ADDR_W'($urandom); write_data = $urandom;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_valid = 0; mem_read = 0; mem_wr = 0; funct3 = 0; addr = 0; write_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({misaligned, illegal, bus_err}), 32'd0);
    check("rst_req", 32'({bus.req, bus.we}), 32'd0);
    check("rst_wstrb", 32'(bus.wstrb), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    issue(0, 1, F3_W, 12'h010, 32'hDEADBEEF, 0, 0, 1, 0);
    issue(0, 1, F3_B, 12'h013, 32'h000000A5, 0, 0, 1, 0);
    issue(0, 1, F3_H, 12'h012, 32'h00001234, 0, 1, 1, 0);
    issue(1, 0, F3_B, 12'h003, 0, 32'h80FF7F01, 0, 1, 0);
    issue(1, 0, F3_BU, 12'h003, 0, 32'h80FF7F01, 0, 1, 0);
    issue(1, 0, F3_HU, 12'h002, 0, 32'h80FF7F01, 1, 2, 0);
    issue(1, 0, F3_H, 12'h002, 0, 32'h80FF7F01, 0, 1, 0);
    issue(1, 0, F3_W, 12'h006, 0, 0, 0, 1, 0);
    issue(1, 0, 3'd3, 12'h004, 0, 0, 0, 1, 0);
    issue(1, 1, F3_W, 12'h007, 0, 0, 0, 1, 0);
    issue(0, 1, F3_W, 12'h100, 32'hCAFEF00D, 0, 3, 1, 0);
    issue(1, 0, F3_W, 12'h200, 0, 32'h12345678, 0, 1, 1);
    issue(0, 1, F3_W, 12'h204, 32'h0BADC0DE, 0, TIMEOUT - 1, 1, 0);
    issue(0, 1, F3_W, 12'h208, 32'h0BADC0DE, 0, TIMEOUT, 1, 0);
    issue(1, 0, F3_W, 12'h20C, 0, 32'h55AA55AA, 4, TIMEOUT - 5, 0);
    issue(1, 0, F3_W, 12'h210, 0, 32'h55AA55AA, 4, TIMEOUT - 4, 0);
    issue(0, 0, F3_W, 12'h214, 0, 0, 0, 1, 0);

    // Reset while a granted load waits for its data; the late rvalid must be ignored.
    @(posedge clk); #1;
    gnt_wait = 0; rv_wait = 2; never_gnt = 0; mem_word = 32'hFFFFFFFF;
    mem_valid = 1; mem_read = 1; mem_wr = 0; funct3 = F3_W; addr = 12'h040;
    bus_exp_we = 0; bus_exp_addr = 10'h010; bus_exp_strb = 4'b0000; bus_exp_v = 1; busy = 1;
    @(posedge clk); #1 mem_valid = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; busy = 0;
    @(negedge clk);
    check("rst_mid_req", 32'(bus.req), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_load_data", load_data, 32'd0);
    rv_pend = 0;

    for (int t = 0; t < 200; t++) begin
      int r, r2;
      bit rd, wr, ng;
      logic [2:0] f3;
      int gw, rvw;
      r = $urandom_range(0, 99);
      if (r < 45) begin rd = 1; wr = 0; end
      else if (r < 90) begin rd = 0; wr = 1; end
      else if (r < 95) begin rd = 1; wr = 1; end
      else begin rd = 0; wr = 0; end
      if ($urandom_range(0, 9) < 8) f3 = rd ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      r2 = $urandom_range(0, 99);
      gw  = (r2 < 85) ? $urandom_range(0, 3) : $urandom_range(TIMEOUT - 4, TIMEOUT + 1);
      rvw = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 3) : $urandom_range(8, TIMEOUT);
      ng  = ($urandom_range(0, 19) == 0);
      issue(rd, wr, f3, ADDR_W'($urandom), $urandom, $urandom, gw, rvw, ng);
    end

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
